// File: rtl/ch_readout_ctrl_if.sv
// Host/channel-side signal bundle for ch_readout_ctrl.
// Macro CH_READOUT_ABORT_EN adds the ABORT/ABORTED pair.
interface ch_readout_ctrl_if #(
    parameter int NUM_CH = 8,
    parameter int CHW    = $clog2(NUM_CH)
);
    logic              START;
    logic [NUM_CH-1:0] CH_MASK;
    logic [NUM_CH-1:0] CNT_SER_IN;
    logic              INST_READOUT;
    logic [2:0]        SELECT_REG;
    logic [CHW-1:0]    CH_SEL;
    logic              SDO;
    logic              SDO_VALID;
    logic              BUSY;
    logic              DONE;
`ifdef CH_READOUT_ABORT_EN
    logic              ABORT;
    logic              ABORTED;

    modport master (
        output START, CH_MASK, CNT_SER_IN, ABORT,
        input  INST_READOUT, SELECT_REG, CH_SEL, SDO, SDO_VALID, BUSY, DONE, ABORTED
    );
    modport slave (
        input  START, CH_MASK, CNT_SER_IN, ABORT,
        output INST_READOUT, SELECT_REG, CH_SEL, SDO, SDO_VALID, BUSY, DONE, ABORTED
    );
`else
    modport master (
        output START, CH_MASK, CNT_SER_IN,
        input  INST_READOUT, SELECT_REG, CH_SEL, SDO, SDO_VALID, BUSY, DONE
    );
    modport slave (
        input  START, CH_MASK, CNT_SER_IN,
        output INST_READOUT, SELECT_REG, CH_SEL, SDO, SDO_VALID, BUSY, DONE
    );
`endif
endinterface

// File: rtl/ch_readout_ctrl.sv
// Multi-channel readout sequencer: latch pulse, byte stepping aligned to the
// serializer bit phase, SDO mux. Optional abort under CH_READOUT_ABORT_EN.
module ch_readout_ctrl #(
    parameter int NUM_CH    = 8,
    parameter int NUM_BYTES = 7,
    parameter int CHW       = $clog2(NUM_CH)
) (
    input logic               SPI_CLK,
    input logic               RST,
    ch_readout_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ALIGN, S_SHIFT, S_FIN} state_e;

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [CHW-1:0]    ch_sel_q, ch_sel_d;
    logic [CHW-1:0]    ch_dly_q;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] rem_mask;
    logic              vld_q;
`ifdef CH_READOUT_ABORT_EN
    logic              abort_pend_q, abort_pend_d;
    logic              aborted_q, aborted_d;
    logic              abort_hit;
`endif

    function automatic logic [CHW-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        lowest_set = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) lowest_set = CHW'(i);
    endfunction

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        ch_sel_d   = ch_sel_q;
        mask_d     = mask_q;
        // Channels still owed a readout once the current one finishes.
        rem_mask   = mask_q & ~(NUM_CH'(1) << ch_sel_q);
`ifdef CH_READOUT_ABORT_EN
        abort_hit    = abort_pend_q | bus.ABORT;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
`ifdef CH_READOUT_ABORT_EN
                    aborted_d = 1'b0;
`endif
                    if (|bus.CH_MASK) begin
                        mask_d     = bus.CH_MASK;
                        ch_sel_d   = lowest_set(bus.CH_MASK);
                        byte_idx_d = '0;
                        state_d    = S_LATCH;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_LATCH: state_d = S_ALIGN;
            S_ALIGN: begin
                if (bit_cnt_q == 3'd7) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_cnt_q == 3'd7) begin
                    if (byte_idx_q != 3'(NUM_BYTES - 1)) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end else begin
                        byte_idx_d = '0;
                        if (rem_mask == '0) begin
                            state_d = S_FIN;
                        end else begin
                            mask_d   = rem_mask;
                            ch_sel_d = lowest_set(rem_mask);
                        end
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef CH_READOUT_ABORT_EN
        // Abort is held pending so SHIFT can finish the byte in flight.
        if (state_q == S_LATCH || state_q == S_ALIGN || state_q == S_SHIFT) begin
            abort_pend_d = abort_hit;
            if (abort_hit && (state_q == S_ALIGN ||
                              (state_q == S_SHIFT && bit_cnt_q == 3'd7))) begin
                state_d      = S_FIN;
                aborted_d    = 1'b1;
                abort_pend_d = 1'b0;
            end
        end
`endif
        if (state_d == S_FIN && state_q != S_FIN) begin
            byte_idx_d = '0;
            ch_sel_d   = '0;
            mask_d     = '0;
        end
    end

    always_ff @(posedge SPI_CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            ch_sel_q     <= '0;
            ch_dly_q     <= '0;
            mask_q       <= '0;
            vld_q        <= 1'b0;
`ifdef CH_READOUT_ABORT_EN
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            // Free-running so it stays phase-equal with the channel serializers.
            bit_cnt_q    <= bit_cnt_q + 3'd1;
            byte_idx_q   <= byte_idx_d;
            ch_sel_q     <= ch_sel_d;
            ch_dly_q     <= ch_sel_q;
            mask_q       <= mask_d;
            vld_q        <= (state_q == S_SHIFT);
`ifdef CH_READOUT_ABORT_EN
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
`endif
        end
    end

    // Serializer output is registered, so the data mux uses the delayed select.
    assign bus.SDO          = vld_q & bus.CNT_SER_IN[ch_dly_q];
    assign bus.SDO_VALID    = vld_q;
    assign bus.INST_READOUT = (state_q == S_LATCH);
    assign bus.SELECT_REG   = byte_idx_q;
    assign bus.CH_SEL       = ch_sel_q;
    assign bus.BUSY         = (state_q != S_IDLE);
    assign bus.DONE         = (state_q == S_FIN);
`ifdef CH_READOUT_ABORT_EN
    assign bus.ABORTED      = aborted_q;
`endif

endmodule

// File: tb/tb_ch_readout_ctrl.sv
// Scoreboard bench for ch_readout_ctrl: directed readouts push expected SDO
// bits and events; a negedge monitor pops and compares.
module tb_ch_readout_ctrl;
    localparam int NUM_CH = 8;
    localparam int NB     = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ch_readout_ctrl_if #(.NUM_CH(NUM_CH)) bus ();
    ch_readout_ctrl #(.NUM_CH(NUM_CH), .NUM_BYTES(NB)) dut (
        .SPI_CLK(clk), .RST(rst), .bus(bus)
    );

    typedef struct {int ch; int byt; int pos; logic val;} bit_t;
    typedef struct {int cyc; logic ab;} done_t;

    bit_t  bq[$];
    int    lq[$];
    done_t dq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    logic [63:0]       pat [NUM_CH];
    logic [2:0]        pos;
    logic [NUM_CH-1:0] ser;

    // Channel serializer model: registered bit, MSB of the selected byte first.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
            ser <= '0;
        end else begin
            pos <= pos + 3'd1;
            for (int i = 0; i < NUM_CH; i++)
                ser[i] <= pat[i][{bus.SELECT_REG, ~pos}];
        end
    end
    assign bus.CNT_SER_IN = ser;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none at cycle %0d", nm, cyc);
    endtask

    logic [2:0]        prev_sel;
    logic [2:0]        prev_ch;
    logic [2:0]        prev_pos;
    logic              prev_done;

    always @(negedge clk) begin : monitor
        bit_t  e;
        done_t d;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (bus.SDO_VALID) begin
                if (bq.size() == 0) fail_now("sdo_unexpected");
                else begin
                    e = bq.pop_front();
                    chk("sdo", bus.SDO, e.val);
                    chk("ch_sel", prev_ch, e.ch);
                    chk("select_reg", prev_sel, e.byt);
                    chk("bit_phase", prev_pos, e.pos);
                end
            end else begin
                chk("sdo_idle", bus.SDO, 0);
            end
            if (bus.INST_READOUT) begin
                if (lq.size() == 0) fail_now("inst_unexpected");
                else chk("inst_cycle", cyc, lq.pop_front());
            end
            if (bus.DONE) begin
                chk("busy_at_done", bus.BUSY, 1);
                chk("bits_left_at_done", bq.size(), 0);
                if (dq.size() == 0) fail_now("done_unexpected");
                else begin
                    d = dq.pop_front();
                    if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
`ifdef CH_READOUT_ABORT_EN
                    chk("aborted", bus.ABORTED, d.ab);
`endif
                end
            end
            if (prev_done) chk("busy_after_done", bus.BUSY, 0);
            prev_done = bus.DONE;
        end
        prev_ch  = bus.CH_SEL;
        prev_sel = bus.SELECT_REG;
        prev_pos = pos;
    end

    task automatic push_ch(input int ch, input int nbytes);
        for (int b = 0; b < nbytes; b++)
            for (int k = 0; k < 8; k++)
                bq.push_back('{ch, b, k, pat[ch][8*b + 7 - k]});
    endtask

    // Caller is positioned at a negedge.
    task automatic issue(input logic [7:0] m, input logic ab);
        if (m != 0) lq.push_back(cyc + 1);
        dq.push_back('{(m == 0) ? cyc + 1 : -1, ab});
        bus.START   = 1'b1;
        bus.CH_MASK = m;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((bus.BUSY || bq.size() != 0 || dq.size() != 0) && n < budget);
        chk({nm, "_complete"}, (bus.BUSY || bq.size() != 0 || dq.size() != 0), 0);
    endtask

    task automatic wait_for(input string nm, input int sel, input int ch, input int p,
                            input int budget);
        logic ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((sel < 0 || bus.SELECT_REG == sel) && (ch < 0 || bus.CH_SEL == ch) &&
                (p < 0 || pos == p)) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_reached"}, ok, 1);
    endtask

    task automatic out_zero(input string nm);
        chk({nm, "_inst"}, bus.INST_READOUT, 0);
        chk({nm, "_select"}, bus.SELECT_REG, 0);
        chk({nm, "_chsel"}, bus.CH_SEL, 0);
        chk({nm, "_sdo"}, bus.SDO, 0);
        chk({nm, "_sdo_valid"}, bus.SDO_VALID, 0);
        chk({nm, "_busy"}, bus.BUSY, 0);
        chk({nm, "_done"}, bus.DONE, 0);
`ifdef CH_READOUT_ABORT_EN
        chk({nm, "_aborted"}, bus.ABORTED, 0);
`endif
    endtask

    initial begin
        pat[0] = 64'h00_5A_C3_0F_F0_96_69_A5;
        pat[1] = 64'h00_01_02_04_08_10_20_40;
        pat[2] = 64'h00_FE_DC_BA_98_76_54_32;
        pat[3] = 64'h00_80_7F_00_FF_55_AA_11;
        pat[4] = 64'h00_13_57_9B_DF_24_68_AC;
        pat[5] = 64'h00_E1_D2_C3_B4_A5_96_87;
        pat[6] = 64'h00_3C_C3_3C_C3_0F_F0_0F;
        pat[7] = 64'h00_DE_AD_BE_EF_CA_FE_42;
        bus.START   = 1'b0;
        bus.CH_MASK = '0;
`ifdef CH_READOUT_ABORT_EN
        bus.ABORT   = 1'b0;
`endif
        #2;
        out_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Full mask, START issued while bit_cnt==3.
        wait_for("phase3", -1, -1, 3, 16);
        for (int c = 0; c < NUM_CH; c++) push_ch(c, NB);
        issue(8'hFF, 1'b0);
        wait_idle("full_ff", 1000);

        // Sparse mask: channels 0 and 2.
        push_ch(0, NB);
        push_ch(2, NB);
        @(negedge clk);
        issue(8'h05, 1'b0);
        wait_idle("mask_05", 400);

`ifdef CH_READOUT_ABORT_EN
        // Abort during bit 4 of ch0 byte 2: byte 2 completes, then FIN.
        push_ch(0, 3);
        @(negedge clk);
        issue(8'h03, 1'b1);
        wait_for("abort_point", 2, 0, 4, 100);
        bus.ABORT = 1'b1;
        @(negedge clk);
        bus.ABORT = 1'b0;
        wait_idle("abort", 200);
`endif

        // Empty mask: straight to FIN.
        @(negedge clk);
        issue(8'h00, 1'b0);
        wait_idle("mask_00", 20);

        // START and mask change while busy are ignored.
        push_ch(0, NB);
        @(negedge clk);
        issue(8'h01, 1'b0);
        repeat (5) @(negedge clk);
        bus.START   = 1'b1;
        bus.CH_MASK = 8'hFF;
        @(negedge clk);
        bus.START = 1'b0;
        wait_idle("busy_start", 200);

        // Asynchronous reset mid-byte at SELECT_REG==3.
        for (int c = 0; c < NUM_CH; c++) push_ch(c, NB);
        @(negedge clk);
        issue(8'hFF, 1'b0);
        wait_for("sel3", 3, -1, -1, 200);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        out_zero("async_reset");
        bq.delete();
        lq.delete();
        dq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Clean full readout after reset.
        for (int c = 0; c < NUM_CH; c++) push_ch(c, NB);
        @(negedge clk);
        issue(8'hFF, 1'b0);
        wait_idle("post_reset_ff", 1000);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
